// File: rtl/exe_stage_if.sv
// Decode-to-execute bundle plus the execute stage's feedback and EX/MEM outputs.
// The master side is the decode/hazard/fetch logic; the slave side is exe_stage.
interface exe_stage_if;
  logic        hazard;
  logic [31:0] pcIn;
  logic [3:0]  aluCmd;
  logic        memRead;
  logic        memWrite;
  logic        wbEn;
  logic        branch;
  logic        s;
  logic        imm;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [11:0] shiftOperand;
  logic [23:0] imm24;
  logic [3:0]  dest;

  logic [3:0]  status;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic [3:0]  idexDest;
  logic        idexWbEn;
  logic        exValid;
  logic        exWbEn;
  logic        exMemRead;
  logic        exMemWrite;
  logic [3:0]  exDest;
  logic [31:0] aluResult;
  logic [31:0] storeVal;

  modport master (
    output hazard, pcIn, aluCmd, memRead, memWrite, wbEn, branch, s, imm,
           reg1, reg2, shiftOperand, imm24, dest,
    input  status, branchTaken, branchAddr, idexDest, idexWbEn, exValid, exWbEn,
           exMemRead, exMemWrite, exDest, aluResult, storeVal
  );

  modport slave (
    input  hazard, pcIn, aluCmd, memRead, memWrite, wbEn, branch, s, imm,
           reg1, reg2, shiftOperand, imm24, dest,
    output status, branchTaken, branchAddr, idexDest, idexWbEn, exValid, exWbEn,
           exMemRead, exMemWrite, exDest, aluResult, storeVal
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage of the ARM-subset pipeline: ID/EX register, operand-2 shifter, ALU,
// branch target adder, NZCV status register and EX/MEM register.
module exe_stage #(
  parameter logic [3:0]  STATUS_RST = 4'b0000,
  parameter int unsigned BR_SHIFT   = 2
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  localparam logic [3:0] AluMov = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluAdc = 4'b0011;
  localparam logic [3:0] AluSub = 4'b0100;
  localparam logic [3:0] AluSbc = 4'b0101;
  localparam logic [3:0] AluAnd = 4'b0110;
  localparam logic [3:0] AluOrr = 4'b0111;
  localparam logic [3:0] AluEor = 4'b1000;
  localparam logic [3:0] AluMvn = 4'b1001;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_cmd;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        branch;
    logic        s;
    logic        imm;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [11:0] shift_op;
    logic [23:0] imm24;
    logic [3:0]  dest;
  } idex_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[31:0];
  endfunction

  idex_t       idex_q, idex_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_wb_en_q, ex_wb_en_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic        ex_mem_write_q, ex_mem_write_d;
  logic [3:0]  ex_dest_q, ex_dest_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_val_q, store_val_d;
  logic [3:0]  status_q, status_d;

  logic        branch_taken;
  logic [31:0] branch_off;
  logic [31:0] val2;
  logic [4:0]  sh_amt;
  logic [4:0]  rot_amt;
  logic [3:0]  op;
  logic        sub_op;
  logic [31:0] b_op;
  logic        cin;
  logic [32:0] sum;
  logic [31:0] res;
  logic        c_new;
  logic        v_new;
  logic        flag_upd;

  assign branch_taken = idex_q.valid & idex_q.branch;
  assign branch_off   = {{8{idex_q.imm24[23]}}, idex_q.imm24} << BR_SHIFT;

  // ID/EX: a stall or a taken branch in EX replaces the ID instruction with a bubble.
  always_comb begin
    idex_d = '0;
    if (!(bus.hazard | branch_taken)) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = bus.pcIn;
      idex_d.alu_cmd   = bus.aluCmd;
      idex_d.mem_read  = bus.memRead;
      idex_d.mem_write = bus.memWrite;
      idex_d.wb_en     = bus.wbEn;
      idex_d.branch    = bus.branch;
      idex_d.s         = bus.s;
      idex_d.imm       = bus.imm;
      idex_d.reg1      = bus.reg1;
      idex_d.reg2      = bus.reg2;
      idex_d.shift_op  = bus.shiftOperand;
      idex_d.imm24     = bus.imm24;
      idex_d.dest      = bus.dest;
    end
  end

  // Operand 2: raw offset for loads/stores, rotated immediate, or shifted register.
  always_comb begin
    sh_amt  = idex_q.shift_op[11:7];
    rot_amt = {idex_q.shift_op[11:8], 1'b0};
    val2    = idex_q.reg2;
    if (idex_q.mem_read | idex_q.mem_write) begin
      val2 = {20'b0, idex_q.shift_op};
    end else if (idex_q.imm) begin
      val2 = ror32({24'b0, idex_q.shift_op[7:0]}, rot_amt);
    end else if (sh_amt != 5'd0) begin
      case (idex_q.shift_op[6:5])
        2'b00:   val2 = idex_q.reg2 << sh_amt;
        2'b01:   val2 = idex_q.reg2 >> sh_amt;
        2'b10:   val2 = 32'($signed(idex_q.reg2) >>> sh_amt);
        default: val2 = ror32(idex_q.reg2, sh_amt);
      endcase
    end
  end

  // ALU; subtraction is A + ~B + cin so the carry out is the ARM "no borrow" flag.
  always_comb begin
    op       = (idex_q.mem_read | idex_q.mem_write) ? AluAdd : idex_q.alu_cmd;
    sub_op   = (op == AluSub) | (op == AluSbc);
    b_op     = sub_op ? ~val2 : val2;
    cin      = 1'b0;
    sum      = '0;
    res      = '0;
    c_new    = status_q[1];
    v_new    = status_q[0];
    flag_upd = 1'b0;
    case (op)
      AluMov: begin res = val2;               flag_upd = 1'b1; end
      AluMvn: begin res = ~val2;              flag_upd = 1'b1; end
      AluAnd: begin res = idex_q.reg1 & val2; flag_upd = 1'b1; end
      AluOrr: begin res = idex_q.reg1 | val2; flag_upd = 1'b1; end
      AluEor: begin res = idex_q.reg1 ^ val2; flag_upd = 1'b1; end
      AluAdd, AluAdc, AluSub, AluSbc: begin
        if (op == AluSub) begin
          cin = 1'b1;
        end else if ((op == AluAdc) || (op == AluSbc)) begin
          cin = status_q[1];
        end
        sum      = {1'b0, idex_q.reg1} + {1'b0, b_op} + {32'b0, cin};
        res      = sum[31:0];
        c_new    = sum[32];
        v_new    = (idex_q.reg1[31] == b_op[31]) && (res[31] != idex_q.reg1[31]);
        flag_upd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (idex_q.valid & idex_q.s & ~idex_q.branch & flag_upd) begin
      status_d = {res[31], (res == 32'd0), c_new, v_new};
    end
    ex_valid_d     = idex_q.valid & ~idex_q.branch;
    ex_wb_en_d     = ex_valid_d & idex_q.wb_en;
    ex_mem_read_d  = ex_valid_d & idex_q.mem_read;
    ex_mem_write_d = ex_valid_d & idex_q.mem_write;
    ex_dest_d      = idex_q.dest;
    alu_result_d   = res;
    store_val_d    = idex_q.reg2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q         <= '0;
      ex_valid_q     <= 1'b0;
      ex_wb_en_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_dest_q      <= '0;
      alu_result_q   <= '0;
      store_val_q    <= '0;
      status_q       <= STATUS_RST;
    end else begin
      idex_q         <= idex_d;
      ex_valid_q     <= ex_valid_d;
      ex_wb_en_q     <= ex_wb_en_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_dest_q      <= ex_dest_d;
      alu_result_q   <= alu_result_d;
      store_val_q    <= store_val_d;
      status_q       <= status_d;
    end
  end

  assign bus.status      = status_q;
  assign bus.branchTaken = branch_taken;
  assign bus.branchAddr  = idex_q.pc + branch_off;
  assign bus.idexDest    = idex_q.dest;
  assign bus.idexWbEn    = idex_q.wb_en & idex_q.valid;
  assign bus.exValid     = ex_valid_q;
  assign bus.exWbEn      = ex_wb_en_q;
  assign bus.exMemRead   = ex_mem_read_q;
  assign bus.exMemWrite  = ex_mem_write_q;
  assign bus.exDest      = ex_dest_q;
  assign bus.aluResult   = alu_result_q;
  assign bus.storeVal    = store_val_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of single-instruction vectors with hand-computed
// results and flags, plus sequences for branch squash, hazard bubbles and async reset.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        s;
    logic        im;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [11:0] so;
    logic [3:0]  dst;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [3:0] cmd, input logic mr, mw, wb, s,
                         im, input logic [31:0] r1, r2, input logic [11:0] so,
                         input logic [3:0] dst, input logic [31:0] exp_res,
                         input logic [3:0] exp_st);
    vec_t v;
    v.name = name; v.cmd = cmd; v.mr = mr; v.mw = mw; v.wb = wb; v.s = s; v.im = im;
    v.r1 = r1; v.r2 = r2; v.so = so; v.dst = dst; v.exp_res = exp_res; v.exp_st = exp_st;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hz, br, input logic [31:0] pc, input logic [3:0] cmd,
                       input logic mr, mw, wb, s, im, input logic [31:0] r1, r2,
                       input logic [11:0] so, input logic [23:0] i24, input logic [3:0] dst);
    bus.hazard = hz; bus.branch = br; bus.pcIn = pc; bus.aluCmd = cmd;
    bus.memRead = mr; bus.memWrite = mw; bus.wbEn = wb; bus.s = s; bus.imm = im;
    bus.reg1 = r1; bus.reg2 = r2; bus.shiftOperand = so; bus.imm24 = i24; bus.dest = dst;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 24'h0,
          4'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exValid"},   32'(bus.exValid), 32'd0);
    chk({tag, "_exCtrl"},    32'({bus.exWbEn, bus.exMemRead, bus.exMemWrite}), 32'd0);
    chk({tag, "_exDest"},    32'(bus.exDest), 32'd0);
    chk({tag, "_aluResult"}, bus.aluResult, 32'd0);
    chk({tag, "_storeVal"},  bus.storeVal, 32'd0);
    chk({tag, "_status"},    32'(bus.status), 32'd0);
    chk({tag, "_idex"},      32'({bus.idexWbEn, bus.idexDest}), 32'd0);
    chk({tag, "_branch"},    32'(bus.branchTaken), 32'd0);
    chk({tag, "_brAddr"},    bus.branchAddr, 32'd0);
  endtask

  initial begin
    //      name         cmd  mr mw wb s  im r1            r2            so      dst  result        nzcv
    add_vec("adds_ovf",  4'h2, 0, 0, 1, 1, 1, 32'h7FFFFFFF, 32'h0,        12'h001, 4'd1, 32'h80000000, 4'b1001);
    add_vec("subs_eq",   4'h4, 0, 0, 1, 1, 0, 32'h5,        32'h5,        12'h000, 4'd2, 32'h0,        4'b0110);
    add_vec("mov_rot",   4'h1, 0, 0, 1, 0, 1, 32'h0,        32'h0,        12'h4FF, 4'd3, 32'hFF000000, 4'b0110);
    add_vec("movs_rot",  4'h1, 0, 0, 1, 1, 1, 32'h0,        32'h0,        12'h4FF, 4'd4, 32'hFF000000, 4'b1010);
    add_vec("adds_cry",  4'h2, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        12'h001, 4'd5, 32'h0,        4'b0110);
    add_vec("adc_c1",    4'h3, 0, 0, 1, 0, 0, 32'h0,        32'h0,        12'h000, 4'd6, 32'h1,        4'b0110);
    add_vec("sbcs_c1",   4'h5, 0, 0, 1, 1, 0, 32'hA,        32'h3,        12'h000, 4'd7, 32'h7,        4'b0010);
    add_vec("subs_neg",  4'h4, 0, 0, 1, 1, 0, 32'h3,        32'h5,        12'h000, 4'd8, 32'hFFFFFFFE, 4'b1000);
    add_vec("sbc_c0",    4'h5, 0, 0, 1, 0, 0, 32'hA,        32'h3,        12'h000, 4'd9, 32'h6,        4'b1000);
    add_vec("adcs_c0",   4'h3, 0, 0, 1, 1, 0, 32'h1,        32'h2,        12'h000, 4'd10, 32'h3,       4'b0000);
    add_vec("mov_lsr",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h80000000, 12'h220, 4'd11, 32'h08000000, 4'b0000);
    add_vec("mov_asr",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h80000000, 12'h240, 4'd12, 32'hF8000000, 4'b0000);
    add_vec("mov_ror",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h0000000F, 12'h260, 4'd13, 32'hF0000000, 4'b0000);
    add_vec("add_lsl",   4'h2, 0, 0, 1, 0, 0, 32'h1,        32'h0000000F, 12'h200, 4'd14, 32'h000000F1, 4'b0000);
    add_vec("ands_zero", 4'h6, 0, 0, 1, 1, 0, 32'hF0,       32'h0F,       12'h000, 4'd15, 32'h0,        4'b0100);
    add_vec("orr",       4'h7, 0, 0, 1, 0, 0, 32'hF0,       32'h0F,       12'h000, 4'd1, 32'hFF,        4'b0100);
    add_vec("eor",       4'h8, 0, 0, 1, 0, 0, 32'hFF,       32'h0F,       12'h000, 4'd2, 32'hF0,        4'b0100);
    add_vec("mvns",      4'h9, 0, 0, 1, 1, 1, 32'h0,        32'h0,        12'h000, 4'd3, 32'hFFFFFFFF,  4'b1000);
    add_vec("undef",     4'h0, 0, 0, 1, 1, 0, 32'h5,        32'h5,        12'h000, 4'd4, 32'h0,         4'b1000);
    add_vec("ldr",       4'h2, 1, 0, 1, 0, 0, 32'h1000,     32'hDEAD,     12'hFFC, 4'd3, 32'h1FFC,      4'b1000);
    add_vec("str",       4'h2, 0, 1, 0, 0, 0, 32'h2000,     32'hCAFEBABE, 12'h004, 4'd0, 32'h2004,      4'b1000);
    add_vec("subs_vov",  4'h4, 0, 0, 1, 1, 1, 32'h80000000, 32'h0,        12'h001, 4'd6, 32'h7FFFFFFF,  4'b0011);

    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(1'b0, 1'b0, 32'h0, vq[i].cmd, vq[i].mr, vq[i].mw, vq[i].wb, vq[i].s, vq[i].im,
            vq[i].r1, vq[i].r2, vq[i].so, 24'h0, vq[i].dst);
      @(posedge clk);
      @(negedge clk);
      idle();
      @(posedge clk);
      @(negedge clk);
      chk({vq[i].name, "_result"}, bus.aluResult, vq[i].exp_res);
      chk({vq[i].name, "_status"}, 32'(bus.status), 32'(vq[i].exp_st));
      chk({vq[i].name, "_valid"}, 32'(bus.exValid), 32'd1);
      chk({vq[i].name, "_ctrl"}, 32'({bus.exWbEn, bus.exMemRead, bus.exMemWrite}),
          32'({vq[i].wb, vq[i].mr, vq[i].mw}));
      chk({vq[i].name, "_dest"}, 32'(bus.exDest), 32'(vq[i].dst));
      chk({vq[i].name, "_store"}, bus.storeVal, vq[i].r2);
    end

    // Flag-setting branch must not write status (currently 0011).
    drive(1'b0, 1'b1, 32'h100, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 12'h0,
          24'hFFFFFE, 4'h0);
    @(posedge clk);
    @(negedge clk);
    chk("br_taken", 32'(bus.branchTaken), 32'd1);
    chk("br_addr", bus.branchAddr, 32'hF8);
    drive(1'b0, 1'b0, 32'h104, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 32'h0, 12'h001,
          24'h0, 4'd9);
    @(posedge clk);
    @(negedge clk);
    chk("br_ex_valid", 32'(bus.exValid), 32'd0);
    chk("br_ex_wb", 32'(bus.exWbEn), 32'd0);
    chk("br_taken_clr", 32'(bus.branchTaken), 32'd0);
    chk("br_squash_idex", 32'(bus.idexWbEn), 32'd0);
    chk("br_status", 32'(bus.status), 32'b0011);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("br_bubble_valid", 32'(bus.exValid), 32'd0);
    chk("br_bubble_wb", 32'(bus.exWbEn), 32'd0);

    drive(1'b1, 1'b0, 32'h0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 32'h0, 12'h003,
          24'h0, 4'd5);
    @(posedge clk);
    @(negedge clk);
    chk("hz_idex_wb", 32'(bus.idexWbEn), 32'd0);
    bus.hazard = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hz_ex_valid", 32'(bus.exValid), 32'd0);
    chk("hz_ex_wb", 32'(bus.exWbEn), 32'd0);
    chk("hz_idex_wb_rel", 32'(bus.idexWbEn), 32'd1);
    chk("hz_idex_dest", 32'(bus.idexDest), 32'd5);
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("hz_ex_valid_rel", 32'(bus.exValid), 32'd1);
    chk("hz_ex_dest", 32'(bus.exDest), 32'd5);
    chk("hz_result", bus.aluResult, 32'd5);

    // Mid-stream async reset, then the first edge after release still shows a bubble.
    drive(1'b0, 1'b0, 32'h0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h77, 12'h008,
          24'h0, 4'd7);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_bubble", 32'(bus.exValid), 32'd0);
    chk("post_rst_idex_wb", 32'(bus.idexWbEn), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.exValid), 32'd1);
    chk("post_rst_result", bus.aluResult, 32'h48);
    chk("post_rst_ctrl", 32'({bus.exWbEn, bus.exMemRead, bus.exMemWrite}), 32'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
